// File: rtl/xbar_master_port.sv
// xbar_master_port: master-side port of the AXI crossbar.
//
// Registers the outer AR/AW requests in one-entry holding registers and decodes each address
// to a destination slave index at capture. Requests issue into the crossbar subject to
// per-direction outstanding limits. A direction only switches destination once its count
// returns to zero, so responses never interleave across slaves. A write-destination queue
// steers W beats to the slave of their AW, which lets several AWs run ahead of their data.
//
// Optional feature macro: XBAR_DECERR_EN
//   defined   : unmapped addresses decode to index SLAVES and are answered internally with
//               DECERR (read responder FSM plus a write-response generator with an ID queue).
//   undefined : unmapped addresses decode to slave 0; the error responders are not built.
//
// Ports:
//   ACLK, ARESETn            clock, synchronous active-low reset
//   AR*/R*/AW*/W*/B* _M      outer AXI master channels
//   XAR_*, XAR_DEST          crossbar read address (DEST = slave index)
//   XR_*                     arbitrated read data from the crossbar
//   XAW_*, XAW_DEST          crossbar write address
//   XW_*, XW_DEST            crossbar write data, steered by the destination queue
//   XB_*                     arbitrated write response from the crossbar
module xbar_master_port #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 4,
    parameter int unsigned SIZE_WIDTH      = 3,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned SLAVES          = 2,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned WDEST_DEPTH     = 4,
    // Slave i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]; ranges are inclusive.
    parameter logic [SLAVES*ADDR_WIDTH-1:0] ADDR_MAP_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [SLAVES*ADDR_WIDTH-1:0] ADDR_MAP_END  = {32'h1fff_ffff, 32'h0fff_ffff},
    parameter int unsigned DW              = $clog2(SLAVES + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // Outer master: read address
    input  logic [ID_WIDTH-1:0]   ARID_M,
    input  logic [ADDR_WIDTH-1:0] ARADDR_M,
    input  logic [LEN_WIDTH-1:0]  ARLEN_M,
    input  logic [SIZE_WIDTH-1:0] ARSIZE_M,
    input  logic [1:0]            ARBURST_M,
    input  logic                  ARVALID_M,
    output logic                  ARREADY_M,
    // Outer master: read data
    output logic [ID_WIDTH-1:0]   RID_M,
    output logic [DATA_WIDTH-1:0] RDATA_M,
    output logic [1:0]            RRESP_M,
    output logic                  RLAST_M,
    output logic                  RVALID_M,
    input  logic                  RREADY_M,
    // Outer master: write address
    input  logic [ID_WIDTH-1:0]   AWID_M,
    input  logic [ADDR_WIDTH-1:0] AWADDR_M,
    input  logic [LEN_WIDTH-1:0]  AWLEN_M,
    input  logic [SIZE_WIDTH-1:0] AWSIZE_M,
    input  logic [1:0]            AWBURST_M,
    input  logic                  AWVALID_M,
    output logic                  AWREADY_M,
    // Outer master: write data
    input  logic [DATA_WIDTH-1:0] WDATA_M,
    input  logic [STRB_WIDTH-1:0] WSTRB_M,
    input  logic                  WLAST_M,
    input  logic                  WVALID_M,
    output logic                  WREADY_M,
    // Outer master: write response
    output logic [ID_WIDTH-1:0]   BID_M,
    output logic [1:0]            BRESP_M,
    output logic                  BVALID_M,
    input  logic                  BREADY_M,
    // Crossbar read address
    output logic [ID_WIDTH-1:0]   XAR_ID,
    output logic [ADDR_WIDTH-1:0] XAR_ADDR,
    output logic [LEN_WIDTH-1:0]  XAR_LEN,
    output logic [SIZE_WIDTH-1:0] XAR_SIZE,
    output logic [1:0]            XAR_BURST,
    output logic [DW-1:0]         XAR_DEST,
    output logic                  XAR_VALID,
    input  logic                  XAR_READY,
    // Crossbar read data
    input  logic [ID_WIDTH-1:0]   XR_ID,
    input  logic [DATA_WIDTH-1:0] XR_DATA,
    input  logic [1:0]            XR_RESP,
    input  logic                  XR_LAST,
    input  logic                  XR_VALID,
    output logic                  XR_READY,
    // Crossbar write address
    output logic [ID_WIDTH-1:0]   XAW_ID,
    output logic [ADDR_WIDTH-1:0] XAW_ADDR,
    output logic [LEN_WIDTH-1:0]  XAW_LEN,
    output logic [SIZE_WIDTH-1:0] XAW_SIZE,
    output logic [1:0]            XAW_BURST,
    output logic [DW-1:0]         XAW_DEST,
    output logic                  XAW_VALID,
    input  logic                  XAW_READY,
    // Crossbar write data
    output logic [DATA_WIDTH-1:0] XW_DATA,
    output logic [STRB_WIDTH-1:0] XW_STRB,
    output logic                  XW_LAST,
    output logic [DW-1:0]         XW_DEST,
    output logic                  XW_VALID,
    input  logic                  XW_READY,
    // Crossbar write response
    input  logic [ID_WIDTH-1:0]   XB_ID,
    input  logic [1:0]            XB_RESP,
    input  logic                  XB_VALID,
    output logic                  XB_READY
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned QW = $clog2(WDEST_DEPTH) + 1;
    localparam logic [DW-1:0] SinkDest = DW'(SLAVES);

`ifdef XBAR_DECERR_EN
    localparam logic [DW-1:0] UnmappedDest = SinkDest;
`else
    localparam logic [DW-1:0] UnmappedDest = '0;
`endif

    // Lowest-numbered matching slave wins on overlapping ranges.
    function automatic logic [DW-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [DW-1:0] d;
        d = UnmappedDest;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if (addr >= ADDR_MAP_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                addr <= ADDR_MAP_END[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                d = DW'(i);
            end
        end
        return d;
    endfunction

    // AR holding register and issue control
    logic                  ar_v_q;
    logic [ID_WIDTH-1:0]   ar_id_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [LEN_WIDTH-1:0]  ar_len_q;
    logic [SIZE_WIDTH-1:0] ar_size_q;
    logic [1:0]            ar_burst_q;
    logic [DW-1:0]         ar_dest_q;
    logic [CW-1:0]         rd_cnt_q;
    logic [DW-1:0]         rd_last_q;
    logic                  ar_issue_ok, ar_fire, rd_dec;

    // AW holding register and issue control
    logic                  aw_v_q;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [LEN_WIDTH-1:0]  aw_len_q;
    logic [SIZE_WIDTH-1:0] aw_size_q;
    logic [1:0]            aw_burst_q;
    logic [DW-1:0]         aw_dest_q;
    logic [CW-1:0]         wr_cnt_q;
    logic [DW-1:0]         wr_last_q;
    logic                  aw_issue_ok, aw_fire, wr_dec;

    // Write-destination queue
    logic [DW-1:0]         wq_dest_q [WDEST_DEPTH];
    logic [QW-1:0]         wq_wr_q, wq_rd_q;
    logic                  wq_empty, wq_full, wq_pop;
    logic [DW-1:0]         wq_head;

    // Error responder view (tied off when the responders are not built)
    logic                  rerr_idle, rerr_active, rerr_last;
    logic [ID_WIDTH-1:0]   rerr_id;
    logic                  head_sink, berr_pend;
    logic [ID_WIDTH-1:0]   berr_id;

    // ------------------------------------------------------------------ read address
    assign ar_issue_ok = ar_v_q & ((rd_cnt_q == '0) |
                         ((ar_dest_q == rd_last_q) & (rd_cnt_q < CW'(MAX_OUTSTANDING))));
    // Sunk reads wait for the error responder to be free; they never reach the crossbar.
    assign ar_fire   = ar_issue_ok & ((ar_dest_q == SinkDest) ? rerr_idle : XAR_READY);
    assign XAR_VALID = ar_issue_ok & (ar_dest_q != SinkDest);
    assign ARREADY_M = ~ar_v_q | ar_fire;
    assign XAR_ID    = ar_id_q;
    assign XAR_ADDR  = ar_addr_q;
    assign XAR_LEN   = ar_len_q;
    assign XAR_SIZE  = ar_size_q;
    assign XAR_BURST = ar_burst_q;
    assign XAR_DEST  = ar_dest_q;
    assign rd_dec    = RVALID_M & RREADY_M & RLAST_M;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ar_v_q     <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            ar_dest_q  <= '0;
            rd_cnt_q   <= '0;
            rd_last_q  <= '0;
        end else begin
            if (ar_fire) begin
                ar_v_q    <= 1'b0;
                rd_last_q <= ar_dest_q;
            end
            if (ARVALID_M && ARREADY_M) begin
                ar_v_q     <= 1'b1;
                ar_id_q    <= ARID_M;
                ar_addr_q  <= ARADDR_M;
                ar_len_q   <= ARLEN_M;
                ar_size_q  <= ARSIZE_M;
                ar_burst_q <= ARBURST_M;
                ar_dest_q  <= decode(ARADDR_M);
            end
            if (ar_fire && !rd_dec) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end else if (!ar_fire && rd_dec) begin
                rd_cnt_q <= rd_cnt_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ write address
    assign aw_issue_ok = aw_v_q & ~wq_full & ((wr_cnt_q == '0) |
                         ((aw_dest_q == wr_last_q) & (wr_cnt_q < CW'(MAX_OUTSTANDING))));
    assign aw_fire   = aw_issue_ok & ((aw_dest_q == SinkDest) | XAW_READY);
    assign XAW_VALID = aw_issue_ok & (aw_dest_q != SinkDest);
    assign AWREADY_M = ~aw_v_q | aw_fire;
    assign XAW_ID    = aw_id_q;
    assign XAW_ADDR  = aw_addr_q;
    assign XAW_LEN   = aw_len_q;
    assign XAW_SIZE  = aw_size_q;
    assign XAW_BURST = aw_burst_q;
    assign XAW_DEST  = aw_dest_q;
    assign wr_dec    = BVALID_M & BREADY_M;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_v_q     <= 1'b0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            aw_dest_q  <= '0;
            wr_cnt_q   <= '0;
            wr_last_q  <= '0;
        end else begin
            if (aw_fire) begin
                aw_v_q    <= 1'b0;
                wr_last_q <= aw_dest_q;
            end
            if (AWVALID_M && AWREADY_M) begin
                aw_v_q     <= 1'b1;
                aw_id_q    <= AWID_M;
                aw_addr_q  <= AWADDR_M;
                aw_len_q   <= AWLEN_M;
                aw_size_q  <= AWSIZE_M;
                aw_burst_q <= AWBURST_M;
                aw_dest_q  <= decode(AWADDR_M);
            end
            if (aw_fire && !wr_dec) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end else if (!aw_fire && wr_dec) begin
                wr_cnt_q <= wr_cnt_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ write data steering
    // Pointers carry one extra wrap bit to tell full from empty.
    assign wq_empty = (wq_wr_q == wq_rd_q);
    assign wq_full  = (wq_wr_q[QW-1] != wq_rd_q[QW-1]) &&
                      (wq_wr_q[QW-2:0] == wq_rd_q[QW-2:0]);
    assign wq_head  = wq_dest_q[wq_rd_q[QW-2:0]];

    assign XW_VALID = WVALID_M & ~wq_empty & ~head_sink;
    assign XW_DEST  = wq_head;
    assign XW_DATA  = WDATA_M;
    assign XW_STRB  = WSTRB_M;
    assign XW_LAST  = WLAST_M;
    // Sunk bursts hold off while a previous error B is still waiting to be taken.
    assign WREADY_M = ~wq_empty & (head_sink ? ~berr_pend : XW_READY);
    assign wq_pop   = WVALID_M & WREADY_M & WLAST_M;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wq_wr_q <= '0;
            wq_rd_q <= '0;
        end else begin
            if (aw_fire) wq_wr_q <= wq_wr_q + 1'b1;
            if (wq_pop)  wq_rd_q <= wq_rd_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_fire) wq_dest_q[wq_wr_q[QW-2:0]] <= aw_dest_q;
    end

    // ------------------------------------------------------------------ error responders
`ifdef XBAR_DECERR_EN
    typedef enum logic {StIdle, StRerr} rerr_state_e;

    rerr_state_e           rerr_state_q, rerr_state_d;
    logic [ID_WIDTH-1:0]   rerr_id_q;
    logic [LEN_WIDTH-1:0]  rerr_len_q, rerr_beat_q;
    logic                  ar_sink;
    logic [ID_WIDTH-1:0]   wq_id_q [WDEST_DEPTH];
    logic                  berr_pend_q;
    logic [ID_WIDTH-1:0]   berr_id_q;

    assign ar_sink     = ar_fire & (ar_dest_q == SinkDest);
    assign rerr_idle   = (rerr_state_q == StIdle);
    assign rerr_active = (rerr_state_q == StRerr);
    assign rerr_last   = (rerr_beat_q == rerr_len_q);
    assign rerr_id     = rerr_id_q;

    always_comb begin
        rerr_state_d = rerr_state_q;
        unique case (rerr_state_q)
            StIdle: if (ar_sink) rerr_state_d = StRerr;
            StRerr: if (RREADY_M && rerr_last) rerr_state_d = StIdle;
            default: rerr_state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rerr_state_q <= StIdle;
            rerr_id_q    <= '0;
            rerr_len_q   <= '0;
            rerr_beat_q  <= '0;
        end else begin
            rerr_state_q <= rerr_state_d;
            if (ar_sink) begin
                rerr_id_q   <= ar_id_q;
                rerr_len_q  <= ar_len_q;
                rerr_beat_q <= '0;
            end else if (rerr_active && RREADY_M) begin
                rerr_beat_q <= rerr_beat_q + 1'b1;
            end
        end
    end

    // ID queue runs in lockstep with the destination queue.
    always_ff @(posedge ACLK) begin
        if (aw_fire) wq_id_q[wq_wr_q[QW-2:0]] <= aw_id_q;
    end

    assign head_sink = (wq_head == SinkDest);
    assign berr_pend = berr_pend_q;
    assign berr_id   = berr_id_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            berr_pend_q <= 1'b0;
            berr_id_q   <= '0;
        end else if (wq_pop && head_sink) begin
            berr_pend_q <= 1'b1;
            berr_id_q   <= wq_id_q[wq_rd_q[QW-2:0]];
        end else if (berr_pend_q && BREADY_M) begin
            berr_pend_q <= 1'b0;
        end
    end
`else
    assign rerr_idle   = 1'b1;
    assign rerr_active = 1'b0;
    assign rerr_last   = 1'b0;
    assign rerr_id     = '0;
    assign head_sink   = 1'b0;
    assign berr_pend   = 1'b0;
    assign berr_id     = '0;
`endif

    // ------------------------------------------------------------------ response muxing
    always_comb begin
        RID_M    = XR_ID;
        RDATA_M  = XR_DATA;
        RRESP_M  = XR_RESP;
        RLAST_M  = XR_LAST;
        RVALID_M = XR_VALID;
        XR_READY = RREADY_M;
        if (rerr_active) begin
            RID_M    = rerr_id;
            RDATA_M  = '0;
            RRESP_M  = 2'b11;
            RLAST_M  = rerr_last;
            RVALID_M = 1'b1;
            XR_READY = 1'b0;
        end
    end

    always_comb begin
        BID_M    = XB_ID;
        BRESP_M  = XB_RESP;
        BVALID_M = XB_VALID;
        XB_READY = BREADY_M;
        if (berr_pend) begin
            BID_M    = berr_id;
            BRESP_M  = 2'b11;
            BVALID_M = 1'b1;
            XB_READY = 1'b0;
        end
    end

endmodule

// File: tb/tb_xbar_master_port.sv
module tb_xbar_master_port;

    localparam int IW = 4;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int SW = 3;
    localparam int DWD = 32;
    localparam int DW = 2;

    logic ACLK = 1'b0;
    logic ARESETn;
    logic [IW-1:0] ARID_M, AWID_M, RID_M, BID_M, XAR_ID, XAW_ID, XR_ID, XB_ID;
    logic [AW-1:0] ARADDR_M, AWADDR_M, XAR_ADDR, XAW_ADDR;
    logic [LW-1:0] ARLEN_M, AWLEN_M, XAR_LEN, XAW_LEN;
    logic [SW-1:0] ARSIZE_M, AWSIZE_M, XAR_SIZE, XAW_SIZE;
    logic [1:0] ARBURST_M, AWBURST_M, XAR_BURST, XAW_BURST, RRESP_M, BRESP_M, XR_RESP, XB_RESP;
    logic ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M, AWVALID_M, AWREADY_M;
    logic [DWD-1:0] RDATA_M, WDATA_M, XW_DATA, XR_DATA;
    logic [3:0] WSTRB_M, XW_STRB;
    logic WLAST_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;
    logic [DW-1:0] XAR_DEST, XAW_DEST, XW_DEST;
    logic XAR_VALID, XAR_READY, XR_LAST, XR_VALID, XR_READY, XAW_VALID, XAW_READY;
    logic XW_LAST, XW_VALID, XW_READY, XB_VALID, XB_READY;

    int n_pass = 0;
    int n_total = 0;

    always #5 ACLK = ~ACLK;

    xbar_master_port dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
        .XAR_ID(XAR_ID), .XAR_ADDR(XAR_ADDR), .XAR_LEN(XAR_LEN), .XAR_SIZE(XAR_SIZE),
        .XAR_BURST(XAR_BURST), .XAR_DEST(XAR_DEST), .XAR_VALID(XAR_VALID),
        .XAR_READY(XAR_READY),
        .XR_ID(XR_ID), .XR_DATA(XR_DATA), .XR_RESP(XR_RESP), .XR_LAST(XR_LAST),
        .XR_VALID(XR_VALID), .XR_READY(XR_READY),
        .XAW_ID(XAW_ID), .XAW_ADDR(XAW_ADDR), .XAW_LEN(XAW_LEN), .XAW_SIZE(XAW_SIZE),
        .XAW_BURST(XAW_BURST), .XAW_DEST(XAW_DEST), .XAW_VALID(XAW_VALID),
        .XAW_READY(XAW_READY),
        .XW_DATA(XW_DATA), .XW_STRB(XW_STRB), .XW_LAST(XW_LAST), .XW_DEST(XW_DEST),
        .XW_VALID(XW_VALID), .XW_READY(XW_READY),
        .XB_ID(XB_ID), .XB_RESP(XB_RESP), .XB_VALID(XB_VALID), .XB_READY(XB_READY)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance past the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [DW-1:0] dest;
    } dec_vec_t;

    dec_vec_t vecs [8];
    int n_vecs;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{addr: 32'h1000_0040, id: 4'h1, dest: 2'd1};
        vecs[1] = '{addr: 32'h0000_0000, id: 4'h2, dest: 2'd0};
        vecs[2] = '{addr: 32'h0fff_ffff, id: 4'h3, dest: 2'd0};
        vecs[3] = '{addr: 32'h1000_0000, id: 4'h4, dest: 2'd1};
        vecs[4] = '{addr: 32'h1fff_ffff, id: 4'h6, dest: 2'd1};
        n_vecs = 5;
`ifndef XBAR_DECERR_EN
        vecs[5] = '{addr: 32'h2000_0000, id: 4'h7, dest: 2'd0};
        vecs[6] = '{addr: 32'hffff_fffc, id: 4'h8, dest: 2'd0};
        n_vecs = 7;
`endif

        ARESETn = 1'b0;
        ARID_M = '0; ARADDR_M = '0; ARLEN_M = '0; ARSIZE_M = 3'd2; ARBURST_M = 2'b01;
        ARVALID_M = 1'b0; RREADY_M = 1'b1;
        AWID_M = '0; AWADDR_M = '0; AWLEN_M = 4'd1; AWSIZE_M = 3'd2; AWBURST_M = 2'b01;
        AWVALID_M = 1'b0;
        WDATA_M = '0; WSTRB_M = 4'hf; WLAST_M = 1'b0; WVALID_M = 1'b0; BREADY_M = 1'b1;
        XAR_READY = 1'b1; XAW_READY = 1'b1; XW_READY = 1'b1;
        XR_ID = '0; XR_DATA = '0; XR_RESP = '0; XR_LAST = 1'b0; XR_VALID = 1'b0;
        XB_ID = '0; XB_RESP = '0; XB_VALID = 1'b0;

        repeat (3) tick();
        settle();
        chk("rst_arready", ARREADY_M, 1);
        chk("rst_awready", AWREADY_M, 1);
        chk("rst_wready", WREADY_M, 0);
        chk("rst_xar_valid", XAR_VALID, 0);
        chk("rst_xaw_valid", XAW_VALID, 0);
        chk("rst_xw_valid", XW_VALID, 0);
        chk("rst_rvalid", RVALID_M, 0);
        chk("rst_bvalid", BVALID_M, 0);
        chk("rst_xr_ready", XR_READY, 1);
        chk("rst_xb_ready", XB_READY, 1);
        tick();
        ARESETn = 1'b1;

        // Decode table: single-beat read per vector, then its response
        for (int i = 0; i < n_vecs; i++) begin
            tick();
            ARVALID_M = 1'b1; ARADDR_M = vecs[i].addr; ARID_M = vecs[i].id; ARLEN_M = '0;
            settle();
            chk("tbl_arready", ARREADY_M, 1);
            tick();
            ARVALID_M = 1'b0;
            settle();
            chk("tbl_xar_valid", XAR_VALID, 1);
            chk("tbl_xar_dest", XAR_DEST, vecs[i].dest);
            chk("tbl_xar_addr", XAR_ADDR, vecs[i].addr);
            chk("tbl_xar_id", XAR_ID, vecs[i].id);
            tick();
            settle();
            chk("tbl_xar_drop", XAR_VALID, 0);
            XR_VALID = 1'b1; XR_LAST = 1'b1; XR_ID = vecs[i].id; XR_DATA = 32'hA000 + i;
            settle();
            chk("tbl_rvalid", RVALID_M, 1);
            chk("tbl_rdata", RDATA_M, 32'hA000 + i);
            tick();
            XR_VALID = 1'b0; XR_LAST = 1'b0;
        end

        // Destination switch waits for RLAST of the earlier burst
        ARVALID_M = 1'b1; ARADDR_M = 32'h0000_0100; ARID_M = 4'h3; ARLEN_M = 4'd1;
        tick();
        ARADDR_M = 32'h1000_0040; ARID_M = 4'h4; ARLEN_M = 4'd3;
        settle();
        chk("sw_first_valid", XAR_VALID, 1);
        chk("sw_first_dest", XAR_DEST, 0);
        chk("sw_arready_b2b", ARREADY_M, 1);
        tick();
        ARVALID_M = 1'b0;
        settle();
        chk("sw_second_blocked", XAR_VALID, 0);
        XR_VALID = 1'b1; XR_LAST = 1'b0;
        tick();
        XR_LAST = 1'b1;
        settle();
        chk("sw_blocked_last_beat", XAR_VALID, 0);
        tick();
        XR_VALID = 1'b0; XR_LAST = 1'b0;
        settle();
        chk("sw_second_valid", XAR_VALID, 1);
        chk("sw_second_dest", XAR_DEST, 1);
        chk("sw_second_len", XAR_LEN, 3);
        tick();
        for (int b = 0; b < 4; b++) begin
            XR_VALID = 1'b1; XR_LAST = (b == 3); XR_DATA = 32'hB0 + b;
            settle();
            chk("burst_rlast", RLAST_M, (b == 3));
            chk("burst_rdata", RDATA_M, 32'hB0 + b);
            tick();
        end
        XR_VALID = 1'b0; XR_LAST = 1'b0;
        // Count back at zero: a slave-0 read issues straight away
        ARVALID_M = 1'b1; ARADDR_M = 32'h0000_0200; ARLEN_M = '0;
        tick();
        ARVALID_M = 1'b0;
        settle();
        chk("cnt_zero_issue", XAR_VALID, 1);
        chk("cnt_zero_dest", XAR_DEST, 0);
        tick();
        XR_VALID = 1'b1; XR_LAST = 1'b1;
        tick();
        XR_VALID = 1'b0; XR_LAST = 1'b0;

        // W before any AW stalls
        WVALID_M = 1'b1; WLAST_M = 1'b0; WDATA_M = 32'h5555;
        settle();
        chk("w_early_wready", WREADY_M, 0);
        chk("w_early_xw_valid", XW_VALID, 0);
        WVALID_M = 1'b0;

        // Five AWs to slave 1; the fifth stalls on a full destination queue
        for (int i = 0; i < 5; i++) begin
            AWVALID_M = 1'b1; AWADDR_M = 32'h1000_0000 + 32'(i * 256); AWID_M = 4'(i);
            tick();
        end
        AWVALID_M = 1'b0;
        settle();
        chk("q_full_xaw_valid", XAW_VALID, 0);
        chk("q_full_awready", AWREADY_M, 0);
        tick();
        settle();
        chk("q_full_hold", XAW_VALID, 0);
        WVALID_M = 1'b1; WLAST_M = 1'b0; WDATA_M = 32'h11;
        settle();
        chk("w0_xw_valid", XW_VALID, 1);
        chk("w0_xw_dest", XW_DEST, 1);
        chk("w0_wready", WREADY_M, 1);
        chk("w0_xw_data", XW_DATA, 32'h11);
        tick();
        WLAST_M = 1'b1;
        settle();
        chk("q_full_before_pop", XAW_VALID, 0);
        tick();
        WVALID_M = 1'b0; WLAST_M = 1'b0;
        settle();
        chk("q_pop_xaw_valid", XAW_VALID, 1);
        chk("q_pop_xaw_id", XAW_ID, 4);
        tick();
        for (int b = 0; b < 4; b++) begin
            for (int beat = 0; beat < 2; beat++) begin
                WVALID_M = 1'b1; WLAST_M = (beat == 1);
                settle();
                chk("drain_xw_valid", XW_VALID, 1);
                tick();
            end
        end
        WVALID_M = 1'b0; WLAST_M = 1'b0;
        settle();
        chk("drain_empty_wready", WREADY_M, 0);
        for (int i = 0; i < 5; i++) begin
            XB_VALID = 1'b1; XB_ID = 4'(i); XB_RESP = 2'b00;
            settle();
            chk("b_pass_valid", BVALID_M, 1);
            chk("b_pass_id", BID_M, i);
            tick();
        end
        XB_VALID = 1'b0;
        // Switch to slave 0 once all writes are answered
        AWVALID_M = 1'b1; AWADDR_M = 32'h0000_0400; AWID_M = 4'h9;
        tick();
        AWVALID_M = 1'b0;
        settle();
        chk("aw_sw_valid", XAW_VALID, 1);
        chk("aw_sw_dest", XAW_DEST, 0);
        tick();
        WVALID_M = 1'b1; WLAST_M = 1'b1;
        settle();
        chk("w_sw_dest", XW_DEST, 0);
        chk("w_sw_valid", XW_VALID, 1);
        tick();
        WVALID_M = 1'b0; WLAST_M = 1'b0;
        XB_VALID = 1'b1; XB_ID = 4'h9;
        tick();
        XB_VALID = 1'b0;

`ifdef XBAR_DECERR_EN
        // Unmapped read answered internally
        ARVALID_M = 1'b1; ARADDR_M = 32'h2000_0000; ARID_M = 4'h5; ARLEN_M = 4'd2;
        tick();
        ARVALID_M = 1'b0;
        settle();
        chk("derr_no_xar", XAR_VALID, 0);
        chk("derr_rvalid_early", RVALID_M, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            settle();
            chk("derr_rvalid", RVALID_M, 1);
            chk("derr_rresp", RRESP_M, 3);
            chk("derr_rid", RID_M, 5);
            chk("derr_rlast", RLAST_M, (b == 2));
            chk("derr_xr_ready", XR_READY, 0);
            tick();
        end
        settle();
        chk("derr_r_done", RVALID_M, 0);
        // Unmapped write answered internally
        AWVALID_M = 1'b1; AWADDR_M = 32'h3000_0000; AWID_M = 4'h2;
        tick();
        AWVALID_M = 1'b0;
        settle();
        chk("derr_no_xaw", XAW_VALID, 0);
        tick();
        WVALID_M = 1'b1; WLAST_M = 1'b0;
        settle();
        chk("derr_wready", WREADY_M, 1);
        chk("derr_no_xw", XW_VALID, 0);
        tick();
        WLAST_M = 1'b1;
        settle();
        chk("derr_bvalid_early", BVALID_M, 0);
        tick();
        WVALID_M = 1'b0; WLAST_M = 1'b0;
        settle();
        chk("derr_bvalid", BVALID_M, 1);
        chk("derr_bresp", BRESP_M, 3);
        chk("derr_bid", BID_M, 2);
        chk("derr_xb_ready", XB_READY, 0);
        tick();
        settle();
        chk("derr_b_done", BVALID_M, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
